// File: rtl/multicycle_control_fsm.sv
// Control unit for the multi-cycle RV32I core.
// Sequences every instruction through FETCH/DECODE/EXECUTE/MEM/WRITEBACK
// states and drives the datapath enables and mux selects for each state.
//
// Ports:
//   clk, rst_n     clock and synchronous active-low reset
//   op             opcode from the instruction register (stable from DECODE)
//   MemReady       memory access completes this cycle (MEM_HANDSHAKE=1 only)
//   MemReq, MemWrite, IRWrite, PCUpdate, Branch, AdrSrc, RegWrite
//                  datapath strobes and address select
//   ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc
//                  datapath mux selects and ALU control
//   IllegalInstr   pulses in DECODE when the opcode is not recognised
//   Halted         high while parked in HALT
//   InstrRet       retired-instruction count, wraps modulo 2^CNT_W
module multicycle_control_fsm #(
  parameter bit MEM_HANDSHAKE   = 1'b1,
  parameter bit TRAP_ON_ILLEGAL = 1'b1,
  parameter int CNT_W           = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       op,
  input  logic             MemReady,
  output logic             MemReq,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             PCUpdate,
  output logic             Branch,
  output logic             AdrSrc,
  output logic             RegWrite,
  output logic [1:0]       ResultSrc,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [2:0]       ImmSrc,
  output logic             IllegalInstr,
  output logic             Halted,
  output logic [CNT_W-1:0] InstrRet
);

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI,
    AUIPC, ALUWB, BRANCH, JAL, JALR, LINK, LUI, HALT
  } state_t;

  state_t state, next;
  logic   rdy;
  logic   retire;

  // Without the handshake, memory is assumed to answer in a single cycle.
  assign rdy = MEM_HANDSHAKE ? MemReady : 1'b1;

  // A store retires only on the cycle its write is accepted.
  assign retire = (state == MEMWB) || (state == ALUWB) || (state == BRANCH) ||
                  (state == LUI)   || ((state == MEMWRITE) && rdy);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= FETCH;
      InstrRet <= '0;
    end else begin
      state <= next;
      if (retire) InstrRet <= InstrRet + CNT_W'(1);
    end
  end

  always_comb begin
    case (op)
      7'b0000011, 7'b0010011, 7'b1100111: ImmSrc = 3'b000;
      7'b0110111, 7'b0010111:             ImmSrc = 3'b001;
      7'b0100011:                         ImmSrc = 3'b010;
      7'b1100011:                         ImmSrc = 3'b011;
      7'b1101111:                         ImmSrc = 3'b100;
      default:                            ImmSrc = 3'b111;
    endcase
  end

  always_comb begin
    next         = state;
    MemReq       = 1'b0;
    MemWrite     = 1'b0;
    IRWrite      = 1'b0;
    PCUpdate     = 1'b0;
    Branch       = 1'b0;
    AdrSrc       = 1'b0;
    RegWrite     = 1'b0;
    ResultSrc    = 2'b00;
    ALUSrcA      = 2'b00;
    ALUSrcB      = 2'b00;
    ALUOp        = 2'b11;
    IllegalInstr = 1'b0;
    Halted       = 1'b0;
    case (state)
      FETCH: begin
        // PC + 4 is computed and written back the same cycle the IR loads.
        MemReq    = 1'b1;
        ALUSrcB   = 2'b10;
        ALUOp     = 2'b00;
        ResultSrc = 2'b10;
        IRWrite   = rdy;
        PCUpdate  = rdy;
        if (rdy) next = DECODE;
      end
      DECODE: begin
        // Precompute OldPC + imm so BRANCH/JAL find their target in ALUOut.
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        ALUOp   = 2'b00;
        case (op)
          7'd3, 7'd35: next = MEMADR;
          7'd51:       next = EXECR;
          7'd19:       next = EXECI;
          7'd99:       next = BRANCH;
          7'd111:      next = JAL;
          7'd103:      next = JALR;
          7'd55:       next = LUI;
          7'd23:       next = AUIPC;
          default: begin
            IllegalInstr = 1'b1;
            next         = TRAP_ON_ILLEGAL ? HALT : FETCH;
          end
        endcase
      end
      MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ALUOp   = 2'b00;
        next    = (op == 7'd3) ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        MemReq = 1'b1;
        AdrSrc = 1'b1;
        if (rdy) next = MEMWB;
      end
      MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
        next      = FETCH;
      end
      MEMWRITE: begin
        MemReq   = 1'b1;
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
        if (rdy) next = FETCH;
      end
      EXECR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b00;
        ALUOp   = 2'b10;
        next    = ALUWB;
      end
      EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ALUOp   = 2'b10;
        next    = ALUWB;
      end
      AUIPC: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        ALUOp   = 2'b00;
        next    = ALUWB;
      end
      ALUWB: begin
        ResultSrc = 2'b00;
        RegWrite  = 1'b1;
        next      = FETCH;
      end
      BRANCH: begin
        ALUSrcA   = 2'b10;
        ALUSrcB   = 2'b00;
        ALUOp     = 2'b01;
        ResultSrc = 2'b00;
        Branch    = 1'b1;
        next      = FETCH;
      end
      JAL: begin
        ResultSrc = 2'b00;
        PCUpdate  = 1'b1;
        next      = LINK;
      end
      JALR: begin
        ALUSrcA   = 2'b10;
        ALUSrcB   = 2'b01;
        ALUOp     = 2'b00;
        ResultSrc = 2'b10;
        PCUpdate  = 1'b1;
        next      = LINK;
      end
      LINK: begin
        // Return address is OldPC + 4, written back through ALUWB.
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        ALUOp   = 2'b00;
        next    = ALUWB;
      end
      LUI: begin
        ResultSrc = 2'b11;
        RegWrite  = 1'b1;
        next      = FETCH;
      end
      HALT: begin
        Halted = 1'b1;
      end
      default: next = FETCH;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm. Three instances share the
// stimulus: A (handshake on, trap on), B (handshake off, skip illegal),
// C (handshake off, trap on, 4-bit retire counter).
module tb_multicycle_control_fsm;

  localparam int A = 0;
  localparam int B = 1;
  localparam int C = 2;

  // Packed control word:
  // {MemReq,MemWrite,IRWrite,PCUpdate,Branch,AdrSrc,RegWrite,
  //  ResultSrc,ALUSrcA,ALUSrcB,ALUOp,IllegalInstr,Halted}
  localparam logic [16:0] F_RDY   = 17'b1_0_1_1_0_0_0_10_00_10_00_0_0;
  localparam logic [16:0] F_WAIT  = 17'b1_0_0_0_0_0_0_10_00_10_00_0_0;
  localparam logic [16:0] DEC     = 17'b0_0_0_0_0_0_0_00_01_01_00_0_0;
  localparam logic [16:0] DEC_ILL = 17'b0_0_0_0_0_0_0_00_01_01_00_1_0;
  localparam logic [16:0] MEMADR  = 17'b0_0_0_0_0_0_0_00_10_01_00_0_0;
  localparam logic [16:0] MEMRD   = 17'b1_0_0_0_0_1_0_00_00_00_11_0_0;
  localparam logic [16:0] MEMWB   = 17'b0_0_0_0_0_0_1_01_00_00_11_0_0;
  localparam logic [16:0] MEMWR   = 17'b1_1_0_0_0_1_0_00_00_00_11_0_0;
  localparam logic [16:0] EXECR   = 17'b0_0_0_0_0_0_0_00_10_00_10_0_0;
  localparam logic [16:0] ALUWB   = 17'b0_0_0_0_0_0_1_00_00_00_11_0_0;
  localparam logic [16:0] JALR    = 17'b0_0_0_1_0_0_0_10_10_01_00_0_0;
  localparam logic [16:0] LINK    = 17'b0_0_0_0_0_0_0_00_01_10_00_0_0;
  localparam logic [16:0] LUI     = 17'b0_0_0_0_0_0_1_11_00_00_11_0_0;
  localparam logic [16:0] HALT    = 17'b0_0_0_0_0_0_0_00_00_00_11_0_1;

  logic       clk;
  logic       rst_n;
  logic [6:0] op;
  logic       MemReady;

  logic [2:0] memreq, memwrite, irwrite, pcupdate, branch, adrsrc, regwrite;
  logic [2:0] illegal, halted;
  logic [1:0] resultsrc [3];
  logic [1:0] alusrca   [3];
  logic [1:0] alusrcb   [3];
  logic [1:0] aluop     [3];
  logic [2:0] immsrc    [3];
  logic [31:0] instret_a, instret_b;
  logic [3:0]  instret_c;

  int n_checks = 0;
  int n_errors = 0;

  multicycle_control_fsm #(.MEM_HANDSHAKE(1'b1), .TRAP_ON_ILLEGAL(1'b1), .CNT_W(32)) u_a (
    .clk(clk), .rst_n(rst_n), .op(op), .MemReady(MemReady),
    .MemReq(memreq[A]), .MemWrite(memwrite[A]), .IRWrite(irwrite[A]),
    .PCUpdate(pcupdate[A]), .Branch(branch[A]), .AdrSrc(adrsrc[A]),
    .RegWrite(regwrite[A]), .ResultSrc(resultsrc[A]), .ALUSrcA(alusrca[A]),
    .ALUSrcB(alusrcb[A]), .ALUOp(aluop[A]), .ImmSrc(immsrc[A]),
    .IllegalInstr(illegal[A]), .Halted(halted[A]), .InstrRet(instret_a)
  );

  multicycle_control_fsm #(.MEM_HANDSHAKE(1'b0), .TRAP_ON_ILLEGAL(1'b0), .CNT_W(32)) u_b (
    .clk(clk), .rst_n(rst_n), .op(op), .MemReady(MemReady),
    .MemReq(memreq[B]), .MemWrite(memwrite[B]), .IRWrite(irwrite[B]),
    .PCUpdate(pcupdate[B]), .Branch(branch[B]), .AdrSrc(adrsrc[B]),
    .RegWrite(regwrite[B]), .ResultSrc(resultsrc[B]), .ALUSrcA(alusrca[B]),
    .ALUSrcB(alusrcb[B]), .ALUOp(aluop[B]), .ImmSrc(immsrc[B]),
    .IllegalInstr(illegal[B]), .Halted(halted[B]), .InstrRet(instret_b)
  );

  multicycle_control_fsm #(.MEM_HANDSHAKE(1'b0), .TRAP_ON_ILLEGAL(1'b1), .CNT_W(4)) u_c (
    .clk(clk), .rst_n(rst_n), .op(op), .MemReady(MemReady),
    .MemReq(memreq[C]), .MemWrite(memwrite[C]), .IRWrite(irwrite[C]),
    .PCUpdate(pcupdate[C]), .Branch(branch[C]), .AdrSrc(adrsrc[C]),
    .RegWrite(regwrite[C]), .ResultSrc(resultsrc[C]), .ALUSrcA(alusrca[C]),
    .ALUSrcB(alusrcb[C]), .ALUOp(aluop[C]), .ImmSrc(immsrc[C]),
    .IllegalInstr(illegal[C]), .Halted(halted[C]), .InstrRet(instret_c)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [16:0] ctl(input int s);
    return {memreq[s], memwrite[s], irwrite[s], pcupdate[s], branch[s],
            adrsrc[s], regwrite[s], resultsrc[s], alusrca[s], alusrcb[s],
            aluop[s], illegal[s], halted[s]};
  endfunction

  function automatic logic [31:0] cnt(input int s);
    case (s)
      A:       return instret_a;
      B:       return instret_b;
      default: return {28'd0, instret_c};
    endcase
  endfunction

  // Drive MemReady for the coming cycle, then let outputs settle.
  task automatic cyc(input logic mr);
    @(negedge clk);
    MemReady = mr;
    #1;
  endtask

  task automatic expect_dut(input int s, input string tag,
                            input logic [16:0] exp_ctl, input logic [31:0] exp_cnt);
    check_val({tag, "_ctl"}, {15'd0, ctl(s)}, {15'd0, exp_ctl});
    check_val({tag, "_cnt"}, cnt(s), exp_cnt);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n    = 1'b0;
    op       = 7'd51;
    MemReady = 1'b0;

    // R-type, no handshake
    do_reset();
    cyc(0); expect_dut(B, "r_fetch", F_RDY, 0);
    check_val("r_imm", {29'd0, immsrc[B]}, 32'd7);
    cyc(0); expect_dut(B, "r_decode", DEC, 0);
    cyc(0); expect_dut(B, "r_execr", EXECR, 0);
    cyc(0); expect_dut(B, "r_aluwb", ALUWB, 0);
    cyc(0); expect_dut(B, "r_next", F_RDY, 1);

    // Load with two wait cycles in FETCH and in MEMREAD
    op = 7'd3;
    do_reset();
    cyc(0); expect_dut(A, "ld_fw1", F_WAIT, 0);
    cyc(0); expect_dut(A, "ld_fw2", F_WAIT, 0);
    cyc(1); expect_dut(A, "ld_fetch", F_RDY, 0);
    check_val("ld_imm", {29'd0, immsrc[A]}, 32'd0);
    cyc(0); expect_dut(A, "ld_decode", DEC, 0);
    cyc(0); expect_dut(A, "ld_memadr", MEMADR, 0);
    cyc(0); expect_dut(A, "ld_mr1", MEMRD, 0);
    cyc(0); expect_dut(A, "ld_mr2", MEMRD, 0);
    cyc(1); expect_dut(A, "ld_mr3", MEMRD, 0);
    cyc(0); expect_dut(A, "ld_memwb", MEMWB, 0);
    cyc(0); expect_dut(A, "ld_next", F_WAIT, 1);

    // Store with three wait cycles in MEMWRITE
    op = 7'd35;
    do_reset();
    cyc(1); expect_dut(A, "st_fetch", F_RDY, 0);
    check_val("st_imm", {29'd0, immsrc[A]}, 32'd2);
    cyc(0); expect_dut(A, "st_decode", DEC, 0);
    cyc(0); expect_dut(A, "st_memadr", MEMADR, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(0); expect_dut(A, $sformatf("st_wait%0d", i), MEMWR, 0);
    end
    cyc(1); expect_dut(A, "st_memwr", MEMWR, 0);
    cyc(1); expect_dut(A, "st_next", F_RDY, 1);

    // JALR, no handshake
    op = 7'd103;
    do_reset();
    cyc(0); expect_dut(B, "jr_fetch", F_RDY, 0);
    cyc(0); expect_dut(B, "jr_decode", DEC, 0);
    cyc(0); expect_dut(B, "jr_jalr", JALR, 0);
    cyc(0); expect_dut(B, "jr_link", LINK, 0);
    cyc(0); expect_dut(B, "jr_aluwb", ALUWB, 0);
    cyc(0); expect_dut(B, "jr_next", F_RDY, 1);

    // Illegal opcode: A traps, B skips to the next fetch
    op = 7'h7F;
    do_reset();
    cyc(1); expect_dut(A, "il_a_fetch", F_RDY, 0); expect_dut(B, "il_b_fetch", F_RDY, 0);
    check_val("il_imm", {29'd0, immsrc[A]}, 32'd7);
    cyc(1); expect_dut(A, "il_a_dec", DEC_ILL, 0); expect_dut(B, "il_b_dec", DEC_ILL, 0);
    cyc(1); expect_dut(A, "il_a_halt1", HALT, 0); expect_dut(B, "il_b_fetch2", F_RDY, 0);
    cyc(1); expect_dut(A, "il_a_halt2", HALT, 0); expect_dut(B, "il_b_dec2", DEC_ILL, 0);
    cyc(1); expect_dut(A, "il_a_halt3", HALT, 0);
    do_reset();
    cyc(1); expect_dut(A, "il_a_rst", F_RDY, 0);

    // 4-bit counter wraps over 17 LUIs
    op = 7'd55;
    do_reset();
    for (int k = 0; k < 17; k++) begin
      cyc(0); expect_dut(C, $sformatf("lui%0d_fetch", k), F_RDY, 32'(k % 16));
      cyc(0); expect_dut(C, $sformatf("lui%0d_dec", k), DEC, 32'(k % 16));
      cyc(0); expect_dut(C, $sformatf("lui%0d_lui", k), LUI, 32'(k % 16));
    end
    cyc(0); expect_dut(C, "lui_wrap", F_RDY, 1);

    // Reset in the middle of an R-type drops it without retiring
    op = 7'd51;
    cyc(0); expect_dut(C, "mid_decode", DEC, 1);
    cyc(0); expect_dut(C, "mid_execr", EXECR, 1);
    rst_n = 1'b0;
    cyc(0);
    rst_n = 1'b1;
    expect_dut(C, "mid_rst", F_RDY, 0);
    cyc(0); expect_dut(C, "mid_decode2", DEC, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Control unit for the multi-cycle RV32I core generation; replaces the single-cycle main decoder.
- Sequences each instruction through FETCH/DECODE/EXECUTE/MEM/WRITEBACK states and drives datapath enables and mux selects per state.
- Adds an optional memory-ready handshake, configurable illegal-opcode handling, and a retired-instruction counter.

Parameters:
- MEM_HANDSHAKE, 1: 1 = memory states wait for MemReady; 0 = memory treated as ready every cycle.
- TRAP_ON_ILLEGAL, 1: 1 = illegal opcode enters HALT; 0 = illegal opcode is skipped and the next instruction is fetched.
- CNT_W, 32: width of the retired-instruction counter.

Ports:
- clk  input  1  clock.
- rst_n  input  1  synchronous reset, active-low.
- op  input  7  opcode from the instruction register; stable from DECODE onward.
- MemReady  input  1  memory access completes this cycle (ignored when MEM_HANDSHAKE=0).
- MemReq  output  1  memory access request.
- MemWrite  output  1  store strobe.
- IRWrite  output  1  instruction register load.
- PCUpdate  output  1  unconditional PC write.
- Branch  output  1  conditional PC write; datapath gates it with the Zero/compare result.
- AdrSrc  output  1  memory address select: 0 = PC, 1 = Result.
- RegWrite  output  1  register file write.
- ResultSrc  output  2  result select: 00 = ALUOut, 01 = Data, 10 = ALUResult, 11 = ImmExt.
- ALUSrcA  output  2  ALU A select: 00 = PC, 01 = OldPC, 10 = RD1.
- ALUSrcB  output  2  ALU B select: 00 = RD2, 01 = ImmExt, 10 = constant 4.
- ALUOp  output  2  00 = add, 01 = branch compare, 10 = funct-decoded, 11 = idle.
- ImmSrc  output  3  immediate format select.
- IllegalInstr  output  1  one-cycle pulse on an illegal opcode.
- Halted  output  1  high while in HALT.
- InstrRet  output  CNT_W  retired-instruction count.

Behaviour:
- Default output values in every state unless listed: all strobes 0, ResultSrc=00, ALUSrcA=00, ALUSrcB=00, ALUOp=11, AdrSrc=0.
- ImmSrc is combinational from op in all states:
  - 0000011, 0010011, 1100111 -> 000
  - 0110111, 0010111 -> 001
  - 0100011 -> 010
  - 1100011 -> 011
  - 1101111 -> 100
  - otherwise 111
- rdy = MemReady when MEM_HANDSHAKE=1, else 1.
- Reset (rst_n=0 at a clk edge): state <= FETCH, InstrRet <= 0, IllegalInstr <= 0. Outputs then take their FETCH values; Halted=0. Reset mid-instruction abandons the instruction with no retire.
- States, outputs and transitions:
  - FETCH: MemReq=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10; IRWrite=PCUpdate=rdy. Stays in FETCH while !rdy; -> DECODE on rdy.
  - DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch/JAL target into ALUOut). Next state by op:
    - 3, 35 -> MEMADR
    - 51 -> EXECR
    - 19 -> EXECI
    - 99 -> BRANCH
    - 111 -> JAL
    - 103 -> JALR
    - 55 -> LUI
    - 23 -> AUIPC
    - otherwise: IllegalInstr=1 for this cycle, then -> HALT if TRAP_ON_ILLEGAL=1, else -> FETCH.
  - MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00; -> MEMREAD if op=3, else MEMWRITE.
  - MEMREAD: MemReq=1, AdrSrc=1; stays while !rdy; -> MEMWB on rdy.
  - MEMWB: ResultSrc=01, RegWrite=1; -> FETCH.
  - MEMWRITE: MemReq=1, AdrSrc=1, MemWrite=1 (held until rdy); stays while !rdy; -> FETCH on rdy.
  - EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10; -> ALUWB.
  - EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10; -> ALUWB.
  - AUIPC: ALUSrcA=01, ALUSrcB=01, ALUOp=00; -> ALUWB.
  - ALUWB: ResultSrc=00, RegWrite=1; -> FETCH.
  - BRANCH: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1; -> FETCH.
  - JAL: ResultSrc=00, PCUpdate=1; -> LINK.
  - JALR: ALUSrcA=10, ALUSrcB=01, ALUOp=00, ResultSrc=10, PCUpdate=1; -> LINK.
  - LINK: ALUSrcA=01, ALUSrcB=10, ALUOp=00 (OldPC+4); -> ALUWB.
  - LUI: ResultSrc=11, RegWrite=1; -> FETCH.
  - HALT: Halted=1, all strobes 0; stays until reset.
- Retire: InstrRet increments by 1 on the cycle the state is MEMWB, ALUWB, BRANCH, LUI, or MEMWRITE with rdy. It wraps modulo 2^CNT_W. Illegal instructions never retire.
- Latency with MEM_HANDSHAKE=0: R/I/AUIPC 4 cycles, load 5, store 4, branch 3, LUI 3, JAL/JALR 5. Each cycle of MemReady=0 in a memory state adds 1.
- MemReady asserted outside FETCH/MEMREAD/MEMWRITE is ignored.

Test Plan:
- Reset with op=51 held, MEM_HANDSHAKE=0 -> states FETCH, DECODE, EXECR, ALUWB, FETCH. RegWrite=1 only in cycle 4. InstrRet=1 after cycle 4.
- Load (op=3), MEM_HANDSHAKE=1, MemReady low for 2 cycles in both FETCH and MEMREAD -> 9 cycles total. IRWrite is a single pulse. RegWrite with ResultSrc=01 in the last cycle. InstrRet+1.
- Store (op=35) with MemReady held low 3 cycles in MEMWRITE -> MemWrite=1 for 4 cycles. InstrRet increments only on the rdy cycle. Never RegWrite.
- JALR (op=103) -> JALR cycle has PCUpdate=1, ResultSrc=10, ALUSrcA=10. LINK has ALUSrcA=01, ALUSrcB=10. ALUWB has RegWrite=1. 5 cycles total.
- op=7'h7F with TRAP_ON_ILLEGAL=1 -> IllegalInstr=1 for 1 cycle in DECODE, then Halted=1 permanently and InstrRet unchanged. rst_n=0 returns to FETCH. Repeat with TRAP_ON_ILLEGAL=0 -> FETCH follows DECODE and Halted stays 0.
- CNT_W=4: run 17 LUI instructions (op=55) -> InstrRet reads 15 after the 15th, 0 after the 16th, 1 after the 17th. Asserting rst_n=0 mid-EXECR clears InstrRet to 0 with no retire.
